// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU control path:
// opcodes, sequencer states and instruction field positions.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_FETCH,
        ST_DECODE,
        ST_IMM,
        ST_HALT
    } state_e;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_MOV  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_LDI  = 4'hA;
    localparam logic [3:0] OP_JZ   = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int OPC_HI = 7;
    localparam int OPC_LO = 4;
    localparam int RD_HI  = 3;
    localparam int RD_LO  = 2;
    localparam int RS_HI  = 1;
    localparam int RS_LO  = 0;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_MOV) && (op <= OP_SHR);
    endfunction

endpackage

// File: rtl/alu8.sv
// Combinational 8-bit ALU; carry is the ADD carry-out, SUB borrow,
// or the bit shifted out, and zero flags an all-zero result.
module alu8
    import cpu_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] op,
    output logic [7:0] result,
    output logic       carry,
    output logic       zero
);

    logic [8:0] wide;

    always_comb begin
        wide = '0;
        case (op)
            OP_MOV:  wide = {1'b0, b};
            OP_ADD:  wide = {1'b0, a} + {1'b0, b};
            OP_SUB:  wide = {1'b0, a} - {1'b0, b};
            OP_AND:  wide = {1'b0, a & b};
            OP_OR:   wide = {1'b0, a | b};
            OP_XOR:  wide = {1'b0, a ^ b};
            OP_NOT:  wide = {1'b0, ~b};
            OP_SHL:  wide = {a, 1'b0};
            OP_SHR:  wide = {a[0], 1'b0, a[7:1]};
            default: wide = '0;
        endcase
    end

    assign result = wide[7:0];
    assign carry  = wide[8];
    assign zero   = (wide[7:0] == 8'h00);

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer driving the register
// file; fetches bytes over a req/ready handshake.
module control_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [7:0]        mem_rdata,
    output logic              write_enable,
    output logic [1:0]        src1,
    output logic [1:0]        src2,
    output logic [1:0]        dest_reg,
    output logic [7:0]        write_data,
    input  logic [7:0]        src1_data,
    input  logic [7:0]        src2_data,
    output logic [ADDR_W-1:0] pc,
    output logic              flag_z,
    output logic              flag_c,
    output logic              halted
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        ir_q, ir_d;
    logic              z_q, z_d;
    logic              c_q, c_d;

    logic [3:0] opc;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] alu_res;
    logic       alu_c;
    logic       alu_z;

    assign opc = ir_q[OPC_HI:OPC_LO];
    assign rd  = ir_q[RD_HI:RD_LO];
    assign rs  = ir_q[RS_HI:RS_LO];

    alu8 u_alu (
        .a      (src1_data),
        .b      (src2_data),
        .op     (opc),
        .result (alu_res),
        .carry  (alu_c),
        .zero   (alu_z)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            z_q     <= z_d;
            c_q     <= c_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        z_d          = z_q;
        c_d          = c_q;
        mem_req      = 1'b0;
        mem_addr     = '0;
        write_enable = 1'b0;
        src1         = '0;
        src2         = '0;
        dest_reg     = '0;
        write_data   = '0;
        halted       = 1'b0;
        unique case (state_q)
            ST_BOOT: state_d = ST_FETCH;
            ST_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                src1    = rd;
                src2    = rs;
                state_d = ST_FETCH;
                if (is_alu_op(opc)) begin
                    write_enable = 1'b1;
                    dest_reg     = rd;
                    write_data   = alu_res;
                    if (opc != OP_MOV) begin
                        z_d = alu_z;
                        c_d = alu_c;
                    end
                end else if (opc == OP_LDI || opc == OP_JZ
                             || opc == OP_JMP) begin
                    state_d = ST_IMM;
                end else if (opc == OP_HALT) begin
                    state_d = ST_HALT;
                end
            end
            ST_IMM: begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
                if (mem_ready) begin
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = ST_FETCH;
                    if (opc == OP_LDI) begin
                        write_enable = 1'b1;
                        dest_reg     = rd;
                        write_data   = mem_rdata;
                    end else if (opc == OP_JMP
                                 || (opc == OP_JZ && z_q)) begin
                        pc_d = ADDR_W'(mem_rdata);
                    end
                end
            end
            ST_HALT: halted = 1'b1;
            default: state_d = ST_BOOT;
        endcase
    end

    assign pc     = pc_q;
    assign flag_z = z_q;
    assign flag_c = c_q;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: directed program with queued
// expected register writes and fetch addresses.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ready;
    logic [7:0] mem_rdata;
    logic       write_enable;
    logic [1:0] src1, src2, dest_reg;
    logic [7:0] write_data;
    logic [7:0] src1_data, src2_data;
    logic [7:0] pc;
    logic       flag_z, flag_c, halted;

    control_unit #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .write_enable (write_enable),
        .src1         (src1),
        .src2         (src2),
        .dest_reg     (dest_reg),
        .write_data   (write_data),
        .src1_data    (src1_data),
        .src2_data    (src2_data),
        .pc           (pc),
        .flag_z       (flag_z),
        .flag_c       (flag_c),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    logic [7:0] regs [4];

    assign mem_rdata = mem[mem_addr];
    assign src1_data = regs[src1];
    assign src2_data = regs[src2];

    always @(posedge clk)
        if (write_enable) regs[dest_reg] <= write_data;

    typedef struct {
        logic [1:0] rd;
        logic [7:0] data;
        logic       z;
        logic       c;
        logic [7:0] pc;
    } wr_t;

    wr_t        wr_q[$];
    logic [7:0] fa_q[$];
    int         checks = 0;
    int         errors = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_wr(logic [1:0] rd, logic [7:0] d,
                          logic z, logic c, logic [7:0] p);
        wr_t e;
        e.rd = rd; e.data = d; e.z = z; e.c = c; e.pc = p;
        wr_q.push_back(e);
    endtask

    task automatic put(logic [7:0] a, logic [7:0] d);
        mem[a] = d;
    endtask

    // Monitor: compares each write, the flags/pc right after it,
    // and every accepted fetch address.
    bit  pend = 0;
    wr_t last;
    always @(negedge clk) begin
        if (pend) begin
            check("flag_z", 32'(flag_z), 32'(last.z));
            check("flag_c", 32'(flag_c), 32'(last.c));
            check("pc_after", 32'(pc), 32'(last.pc));
            pend = 0;
        end
        if (write_enable) begin
            if (wr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write rd=%0d data=0x%0h",
                         dest_reg, write_data);
            end else begin
                last = wr_q.pop_front();
                check("wr_rd", 32'(dest_reg), 32'(last.rd));
                check("wr_data", 32'(write_data), 32'(last.data));
                pend = 1;
            end
        end
        if (mem_req && mem_ready) begin
            if (fa_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_fetch addr=0x%0h", mem_addr);
            end else begin
                check("fetch_addr", 32'(mem_addr), 32'(fa_q.pop_front()));
            end
        end
    end

    function automatic logic [31:0] all_outs();
        return {8'h0, mem_req, write_enable, halted, flag_z, flag_c,
                mem_addr[0], src1, src2, dest_reg, write_data};
    endfunction

    initial begin
        logic [7:0] fa [32];
        int n;
        reset = 1'b0;
        mem_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
        for (int i = 0; i < 4; i++) regs[i] = 8'h00;

        put(8'h00, 8'hA0); put(8'h01, 8'h0F);
        put(8'h02, 8'hA4); put(8'h03, 8'hF1);
        put(8'h04, 8'h21);
        put(8'h05, 8'hB0); put(8'h06, 8'h20);
        put(8'h20, 8'hA8); put(8'h21, 8'h01);
        put(8'h22, 8'hAC); put(8'h23, 8'h02);
        put(8'h24, 8'h3B);
        put(8'h25, 8'hB0); put(8'h26, 8'h40);
        put(8'h27, 8'hA0); put(8'h28, 8'h01);
        put(8'h29, 8'h90);
        put(8'h2A, 8'hC0); put(8'h2B, 8'hF0);
        put(8'hF0, 8'hA4); put(8'hF1, 8'h80);
        put(8'hF2, 8'h19); put(8'hF3, 8'h84);
        put(8'hF4, 8'h7A); put(8'hF5, 8'h00);
        put(8'hF6, 8'hD0); put(8'hF7, 8'h6B);
        put(8'hF8, 8'h4E); put(8'hF9, 8'h5E);
        put(8'hFA, 8'hC0); put(8'hFB, 8'hFF);
        put(8'hFF, 8'hF0);

        exp_wr(0, 8'h0F, 0, 0, 8'h02);
        exp_wr(1, 8'hF1, 0, 0, 8'h04);
        exp_wr(0, 8'h00, 1, 1, 8'h05);
        exp_wr(2, 8'h01, 1, 1, 8'h22);
        exp_wr(3, 8'h02, 1, 1, 8'h24);
        exp_wr(2, 8'hFF, 0, 1, 8'h25);
        exp_wr(0, 8'h01, 0, 1, 8'h29);
        exp_wr(0, 8'h00, 1, 1, 8'h2A);
        exp_wr(1, 8'h80, 1, 1, 8'hF2);
        exp_wr(2, 8'h80, 1, 1, 8'hF3);
        exp_wr(1, 8'h00, 1, 1, 8'hF4);
        exp_wr(2, 8'h7F, 0, 0, 8'hF5);
        exp_wr(2, 8'h7D, 0, 0, 8'hF8);
        exp_wr(3, 8'h00, 1, 0, 8'hF9);
        exp_wr(3, 8'h7D, 0, 0, 8'hFA);

        fa = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h20,
               8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28,
               8'h29, 8'h2A, 8'h2B, 8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'hF4,
               8'hF5, 8'hF6, 8'hF7, 8'hF8, 8'hF9, 8'hFA, 8'hFB, 8'hFF};
        for (int i = 0; i < 32; i++) fa_q.push_back(fa[i]);

        repeat (2) begin
            @(negedge clk);
            check("rst_outs", all_outs(), 32'h0);
            check("rst_pc", 32'(pc), 32'h0);
        end
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check("boot_outs", all_outs(), 32'h0);
        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            check("stall_req", 32'(mem_req), 32'h1);
            check("stall_addr", 32'(mem_addr), 32'h0);
            check("stall_pc", 32'(pc), 32'h0);
            check("stall_we", 32'(write_enable), 32'h0);
            @(posedge clk);
        end
        #1 mem_ready = 1'b1;

        n = 0;
        while (!halted && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("halt_reached", 32'(halted), 32'h1);
        repeat (3) begin
            @(negedge clk);
            check("halt_flag", 32'(halted), 32'h1);
            check("halt_req", 32'(mem_req), 32'h0);
            check("halt_pc_wrap", 32'(pc), 32'h0);
        end
        check("wr_q_empty", 32'(wr_q.size()), 32'h0);
        check("fa_q_empty", 32'(fa_q.size()), 32'h0);

        @(posedge clk); #1 reset = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        fa_q.push_back(8'h00);
        @(posedge clk); #1 mem_ready = 1'b1;
        @(posedge clk); #1 mem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("imm_req", 32'(mem_req), 32'h1);
        check("imm_addr", 32'(mem_addr), 32'h1);
        #2 reset = 1'b0;
        #1;
        check("async_req_drop", 32'(mem_req), 32'h0);
        check("async_pc", 32'(pc), 32'h0);
        mem_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_we", 32'(write_enable), 32'h0);
            check("rst_req", 32'(mem_req), 32'h0);
        end
        check("no_ldi_write", 32'(regs[0]), 32'h0);
        check("fa_q_empty2", 32'(fa_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU. It sits directly upstream of register_file and drives that block's write_enable, src1, src2, dest_reg and write_data ports.
- It fetches instruction bytes from program memory over a req/ready handshake and reads operands combinationally from the register file.
- It computes results through an internal ALU and writes them back. It also handles immediate loads, jumps and halt.

Parameters:
- RESET_PC, 8'h00, program counter value loaded on reset.
- ADDR_W, 8, program memory address width. pc wraps modulo 2^ADDR_W.

Ports:
- clk  in  1  system clock. All state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_req  out  1  fetch request. Held high until mem_ready is sampled high.
- mem_addr  out  ADDR_W  fetch address. Equals pc while mem_req=1, else 0.
- mem_ready  in  1  memory has accepted the request. mem_rdata is valid in the same cycle.
- mem_rdata  in  8  fetched byte.
- write_enable  out  1  register file write strobe.
- src1  out  2  register file read address A.
- src2  out  2  register file read address B.
- dest_reg  out  2  register file write address.
- write_data  out  8  register file write data.
- src1_data  in  8  register file read data A (combinational).
- src2_data  in  8  register file read data B (combinational).
- pc  out  ADDR_W  current program counter.
- flag_z  out  1  zero flag.
- flag_c  out  1  carry/borrow flag.
- halted  out  1  high in HALT state.

Behaviour:
- Instruction byte layout: ir[7:4] opcode, ir[3:2] rd (also first source), ir[1:0] rs.
- Opcodes:
  - 0 NOP.
  - 1 MOV: rd=rs.
  - 2 ADD: rd=rd+rs.
  - 3 SUB: rd=rd-rs.
  - 4 AND.
  - 5 OR.
  - 6 XOR.
  - 7 NOT: rd=~rs.
  - 8 SHL: rd=rd<<1.
  - 9 SHR: rd=rd>>1 (logical).
  - A LDI: rd=imm.
  - B JZ imm.
  - C JMP imm.
  - D, E: reserved, executed as NOP.
  - F HALT.
  - A, B and C are two-byte instructions; the immediate is the next byte.
- States: BOOT, FETCH, DECODE, IMM, HALT.
- Reset (asserted): state=BOOT, pc=RESET_PC, ir=0, flag_z=0, flag_c=0.
  - All outputs are 0 while reset is low, including mem_req and write_enable.
  - Reset asserted mid-handshake drops mem_req asynchronously; the pending fetch is abandoned.
- BOOT: all outputs 0. Next state FETCH unconditionally.
- FETCH: mem_req=1, mem_addr=pc.
  - On mem_ready=1: ir<=mem_rdata, pc<=pc+1, go to DECODE.
  - Otherwise stay in FETCH; mem_req stays high and mem_addr stays stable.
- DECODE: src1=ir[3:2], src2=ir[1:0].
  - Opcodes 1-9: write_enable=1, dest_reg=ir[3:2], write_data=ALU result, all in this cycle. The register file captures the result on this edge. Go to FETCH.
  - Opcodes 0, D, E: no write, go to FETCH.
  - Opcodes A, B, C: go to IMM.
  - Opcode F: go to HALT.
- IMM: mem_req=1, mem_addr=pc.
  - On mem_ready, pc<=pc+1 by default, then per opcode:
    - LDI: write_enable=1, dest_reg=ir[3:2], write_data=mem_rdata in the same cycle.
    - JMP: pc<=mem_rdata.
    - JZ: pc<=mem_rdata if flag_z=1, else pc+1.
  - Then go to FETCH. Stall without side effects while mem_ready=0.
- HALT: halted=1, mem_req=0, write_enable=0. Exit only via reset.
- write_enable is never high outside DECODE (opcodes 1-9) or the mem_ready cycle of IMM-LDI.
- ALU width and flag rules:
  - All arithmetic is 8-bit.
  - ADD: C = carry out of bit 7.
  - SUB: C = borrow (1 when rd<rs unsigned).
  - SHL: C = old bit7. SHR: C = old bit0.
  - AND, OR, XOR, NOT: C=0.
  - Z = (result==0) for opcodes 2-9, updated on the DECODE edge.
  - MOV, LDI, jumps and NOP leave both flags unchanged.
- pc wraps from 2^ADDR_W-1 to 0 on increment, including when the immediate byte sits at the top address.
- Latency: single-byte ALU op = FETCH wait cycles + 2. Two-byte op = 2 handshakes + 1 DECODE cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams (OP_NOP..OP_HALT),
  - state encoding (ST_BOOT, ST_FETCH, ST_DECODE, ST_IMM, ST_HALT),
  - the instruction field bit positions.
- One combinational sub-module, alu8, has inputs a, b, op and outputs result, carry, zero.
- control_unit instantiates alu8 and holds only state, pc, ir and flags.

Test Plan:
- Reset with reset=0 for 2 cycles, then release -> all outputs 0 during reset; BOOT for one cycle; then mem_req=1, mem_addr=0x00.
- Program LDI r0,0x0F; LDI r1,0xF1; ADD r0,r1 with mem_ready=1 always -> write_enable pulses write 0x0F to r0, then 0xF1 to r1, then 0x00 to r0; after ADD flag_z=1, flag_c=1, pc=0x05.
- JZ 0x20 after the ADD above -> pc=0x20 and next mem_addr=0x20. With flag_z=0, execution continues at pc+2 of the JZ.
- mem_ready held low 3 cycles during FETCH -> mem_req stays 1 and mem_addr stays stable; no write_enable; pc unchanged until the ready cycle.
- SUB r2,r3 with r2=0x01, r3=0x02 -> write_data=0xFF, flag_c=1, flag_z=0.
- SHR of 0x01 -> result 0x00, flag_z=1, flag_c=1.
- HALT at 0xFF -> pc wraps to 0x00, halted=1, mem_req=0 indefinitely.
- Reset asserted mid-IMM -> mem_req drops immediately, pc=RESET_PC, and no register write occurs.
